// File: rtl/diff_freq_cmd_packer.sv
// diff_freq_cmd_packer: latches one channel command into a 9-byte packet and
// feeds it to a UART transmitter one byte at a time over its start/done
// handshake. An optional idle gap can be inserted between bytes.
module diff_freq_cmd_packer #(
    parameter int DATA_BIT = 32,
    parameter int PACK_NUM = 9,
    parameter int GAP_CLK  = 0,
    parameter int GAP_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_cmd_valid,
    output logic                o_cmd_ready,
    input  logic [DATA_BIT-1:0] i_out_pattern,
    input  logic [DATA_BIT-1:0] i_freq_pattern,
    input  logic [3:0]          i_channel,
    input  logic                i_mode,
    output logic                o_tx_start,
    output logic [7:0]          o_tx_data,
    input  logic                i_tx_done_tick,
    output logic                o_busy,
    output logic                o_pkt_done_tick
);

    localparam int               PKT_W    = PACK_NUM * 8;
    localparam logic [3:0]       LAST_IDX = 4'(PACK_NUM - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CLK);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_GAP,
        S_DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [3:0]         idx;
    logic [GAP_W-1:0]   gap_cnt;
    logic [PKT_W-1:0]   pkt_sr;
    logic [7:0]         ctrl_byte;
    logic               accept;
    logic               last_byte;
    logic               byte_done;
    logic               advance;

    // Handshake uses the registered ready, so nothing is taken in the
    // first cycle after reset release before ready has risen.
    assign accept    = i_cmd_valid & o_cmd_ready;
    assign last_byte = (idx == LAST_IDX);
    // A done tick only counts while a byte is actually in flight.
    assign byte_done = (state == S_WAIT) && i_tx_done_tick;
    assign advance   = byte_done && !last_byte;
    assign ctrl_byte = {i_channel, 1'b0, i_mode, 2'b01};

    // The current byte is always the low byte of the packet shift register.
    assign o_tx_data = pkt_sr[7:0];

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode for the byte sequencer.
    always_comb begin
        // NOTE: default first so no path through the case leaves state_nxt
        // unassigned, which would otherwise infer a latch.
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = S_START;
                end
            end
            S_START: begin
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (i_tx_done_tick) begin
                    if (last_byte) begin
                        state_nxt = S_DONE;
                    end else if (GAP_CLK == 0) begin
                        state_nxt = S_START;
                    end else begin
                        state_nxt = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt <= GAP_W'(1)) begin
                    state_nxt = S_START;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Packet datapath, byte index, gap counter and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_sr          <= '0;
            idx             <= '0;
            gap_cnt         <= '0;
            o_cmd_ready     <= 1'b0;
            o_busy          <= 1'b0;
            o_tx_start      <= 1'b0;
            o_pkt_done_tick <= 1'b0;
        end else begin
            // Status flags are registered from the next state so each one
            // is true exactly while the FSM sits in the matching state.
            o_cmd_ready     <= (state_nxt == S_IDLE);
            o_busy          <= (state_nxt != S_IDLE);
            o_tx_start      <= (state_nxt == S_START);
            o_pkt_done_tick <= (state_nxt == S_DONE);

            if (accept) begin
                pkt_sr <= {ctrl_byte, i_freq_pattern, i_out_pattern};
                idx    <= '0;
            end else if (advance) begin
                pkt_sr <= pkt_sr >> 8;
                idx    <= idx + 4'd1;
            end

            if (advance) begin
                gap_cnt <= GAP_LOAD;
            end else if ((state == S_GAP) && (gap_cnt != '0)) begin
                gap_cnt <= gap_cnt - GAP_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_diff_freq_cmd_packer.sv
// Self-checking bench for diff_freq_cmd_packer. Two instances are built, one
// without an inter-byte gap and one with GAP_CLK=3; each is exercised in turn
// by directed and random packets against a byte-level reference model.
module tb_diff_freq_cmd_packer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [1:0]       cmd_valid;
    logic [1:0]       mode;
    logic [1:0]       tx_done;
    logic [1:0][31:0] out_pat;
    logic [1:0][31:0] freq_pat;
    logic [1:0][3:0]  chan;
    wire  [1:0]       cmd_ready;
    wire  [1:0]       tx_start;
    wire  [1:0]       busy;
    wire  [1:0]       pkt_done;
    wire  [1:0][7:0]  tx_data;

    int n_vec = 0;
    int n_err = 0;
    int cur_k = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        diff_freq_cmd_packer #(
            .GAP_CLK(g == 0 ? 0 : 3)
        ) u_dut (
            .clk            (clk),
            .rst            (rst),
            .i_cmd_valid    (cmd_valid[g]),
            .o_cmd_ready    (cmd_ready[g]),
            .i_out_pattern  (out_pat[g]),
            .i_freq_pattern (freq_pat[g]),
            .i_channel      (chan[g]),
            .i_mode         (mode[g]),
            .o_tx_start     (tx_start[g]),
            .o_tx_data      (tx_data[g]),
            .i_tx_done_tick (tx_done[g]),
            .o_busy         (busy[g]),
            .o_pkt_done_tick(pkt_done[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s (dut%0d) @%0t: got %h expected %h", tag, cur_k, $time, got, exp);
        end
    endtask

    function automatic int gap_of(input int k);
        return (k == 0) ? 0 : 3;
    endfunction

    task automatic check_reset_outputs(input int k);
        cur_k = k;
        check("rst_ready", 32'(cmd_ready[k]), 0);
        check("rst_busy",  32'(busy[k]), 0);
        check("rst_start", 32'(tx_start[k]), 0);
        check("rst_data",  32'(tx_data[k]), 0);
        check("rst_done",  32'(pkt_done[k]), 0);
    endtask

    // Sends one command to instance k and plays the UART side: each byte's
    // done tick arrives lat cycles after its start. hold keeps valid high
    // with garbage data during the packet; rst_after pulses reset right after
    // that byte's done tick; stray injects a done tick in byte 2's start cycle.
    task automatic run_pkt(input int k, input logic [31:0] op, input logic [31:0] fp,
                           input logic [3:0] ch, input logic md, input int lat,
                           input bit hold, input int rst_after, input bit stray);
        logic [7:0] exp_b [9];
        int n;
        cur_k = k;
        for (int i = 0; i < 4; i++) begin
            exp_b[i]     = 8'(op >> (8 * i));
            exp_b[i + 4] = 8'(fp >> (8 * i));
        end
        exp_b[8] = 8'(int'(ch) * 16 + int'(md) * 4 + 1);

        cmd_valid[k] = 1'b1;
        out_pat[k]   = op;
        freq_pat[k]  = fp;
        chan[k]      = ch;
        mode[k]      = md;
        n = 0;
        while (cmd_ready[k] !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (cmd_ready[k] !== 1'b1) begin
            check("accept_timeout", 0, 1);
            cmd_valid[k] = 1'b0;
            return;
        end

        @(negedge clk);
        check("start_b0",   32'(tx_start[k]), 1);
        check("ready_drop", 32'(cmd_ready[k]), 0);
        check("busy_on",    32'(busy[k]), 1);
        cmd_valid[k] = hold;
        out_pat[k]   = $urandom;
        freq_pat[k]  = $urandom;
        chan[k]      = 4'($urandom);
        mode[k]      = 1'($urandom);

        for (int b = 0; b < 9; b++) begin
            if (b > 0) begin
                if (b - 1 == rst_after) begin
                    @(negedge clk);
                    tx_done[k]   = 1'b0;
                    cmd_valid[k] = 1'b0;
                    rst          = 1'b1;
                    @(negedge clk);
                    check_reset_outputs(k);
                    rst = 1'b0;
                    for (int c = 0; c < 6; c++) begin
                        @(negedge clk);
                        check("no_done_after_rst", 32'(pkt_done[k]), 0);
                    end
                    check("ready_after_rst", 32'(cmd_ready[k]), 1);
                    return;
                end
                n = 0;
                do begin
                    @(negedge clk);
                    tx_done[k] = 1'b0;
                    n++;
                end while (tx_start[k] !== 1'b1 && n < 64);
                check("start_latency", 32'(n), 32'(gap_of(k) + 1));
                if (tx_start[k] !== 1'b1) return;
            end
            check("byte", 32'(tx_data[k]), 32'(exp_b[b]));
            if (stray && b == 2) tx_done[k] = 1'b1;
            for (int c = 0; c < lat; c++) begin
                @(negedge clk);
                tx_done[k] = 1'b0;
                check("data_stable", 32'(tx_data[k]), 32'(exp_b[b]));
                check("start_pulse", 32'(tx_start[k]), 0);
            end
            tx_done[k] = 1'b1;
        end

        @(negedge clk);
        tx_done[k] = 1'b0;
        check("pkt_done",   32'(pkt_done[k]), 1);
        check("ready_d1",   32'(cmd_ready[k]), 0);
        @(negedge clk);
        check("pkt_done_1", 32'(pkt_done[k]), 0);
        check("ready_d2",   32'(cmd_ready[k]), 1);
        check("busy_off",   32'(busy[k]), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        cmd_valid = '0;
        mode      = '0;
        tx_done   = '0;
        out_pat   = '0;
        freq_pat  = '0;
        chan      = '0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) check_reset_outputs(k);
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            cur_k = k;
            check("ready_release", 32'(cmd_ready[k]), 1);
        end

        // Stray done tick while idle must not disturb the following packet.
        tx_done = 2'b11;
        @(negedge clk);
        tx_done = 2'b00;
        for (int k = 0; k < 2; k++) begin
            cur_k = k;
            check("idle_busy", 32'(busy[k]), 0);
        end

        for (int k = 0; k < 2; k++) begin
            run_pkt(k, 32'h0055_0055, 32'h0000_0000, 4'd0,  1'b0, 3,  1'b0, -1, 1'b0);
            run_pkt(k, 32'hDEAD_BEEF, 32'h0000_FFFF, 4'd13, 1'b1, 10, 1'b0, -1, 1'b1);
            run_pkt(k, $urandom,      $urandom,      4'd14, 1'b0, 2,  1'b1, -1, 1'b0);
            run_pkt(k, $urandom,      $urandom,      4'd15, 1'b0, 1,  1'b0, -1, 1'b0);
            run_pkt(k, $urandom,      $urandom,      4'd7,  1'b1, 4,  1'b0, 3,  1'b0);
            for (int i = 0; i < 8; i++) begin
                run_pkt(k, $urandom, $urandom, 4'($urandom), 1'($urandom),
                        int'($urandom_range(1, 6)),
                        (i < 7) ? 1'($urandom) : 1'b0, -1, 1'($urandom));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/diff_freq_cmd_packer.md
# diff_freq_cmd_packer

Host-side command encoder for the differential-frequency serial output engine. It accepts one channel command (32-bit output pattern, 32-bit frequency pattern, 4-bit channel, mode) over a valid/ready handshake and serializes it into the 9-byte packet that `diff_freq_serial_out` consumes, driving a `UART` transmitter one byte at a time through its start/done handshake. It sits between a controller or sequencer and the UART TX port on the sending side of the link.

## Interface
- `DATA_BIT`, 32, width of each pattern; fixed at 32.
- `PACK_NUM`, 9, bytes per packet; must equal 2*DATA_BIT/8+1.
- `GAP_CLK`, 0, idle clocks inserted between a byte's `i_tx_done_tick` and the next `o_tx_start`; 0 means no gap.
- `GAP_W`, 16, gap counter width; `GAP_CLK` < 2^GAP_W.

Ports:
- `clk` in 1: single clock; all logic rising-edge.
- `rst` in 1: reset, synchronous, active-high.
- `i_cmd_valid` in 1: command present.
- `o_cmd_ready` out 1: command accepted when `i_cmd_valid & o_cmd_ready`.
- `i_out_pattern` in DATA_BIT: output bit pattern.
- `i_freq_pattern` in DATA_BIT: per-bit period select (0 = low-frequency period, 1 = high-frequency period).
- `i_channel` in 4: target channel 0..15.
- `i_mode` in 1: 0 = one-shot, 1 = repeat.
- `o_tx_start` out 1: one-cycle start pulse to UART TX.
- `o_tx_data` out 8: byte to send; valid and stable from the `o_tx_start` cycle until `i_tx_done_tick`.
- `i_tx_done_tick` in 1: UART TX byte-complete tick.
- `o_busy` out 1: packet in progress.
- `o_pkt_done_tick` out 1: one-cycle pulse when the last byte has completed.

## Operation
- Packet byte order:
  - bytes 0–3: `i_out_pattern[7:0]`, `[15:8]`, `[23:16]`, `[31:24]`.
  - bytes 4–7: `i_freq_pattern`, same LSB-first order.
  - byte 8 (control): `{i_channel, 1'b0, i_mode, 2'b01}`.
- On accept, all 72 bits are latched into a packet shift register. Input changes after accept have no effect.
- FSM states:
  - IDLE: `o_cmd_ready=1`; on accept go to START with byte index 0.
  - START: `o_tx_start=1` for exactly one cycle; present `o_tx_data`; go to WAIT.
  - WAIT: hold `o_tx_data`.
    - On `i_tx_done_tick`: if index = PACK_NUM-1, go to DONE.
    - Else if `GAP_CLK`=0, increment index and go to START.
    - Else increment index, load the gap counter, go to GAP.
  - GAP: count `GAP_CLK` cycles, then go to START.
  - DONE: `o_pkt_done_tick=1` for one cycle, then go to IDLE.
- Byte index is 4 bits and counts 0..8. It never wraps past 8.
- `o_busy` = 1 in every state except IDLE.
- `i_tx_done_tick` is ignored in IDLE, START, GAP and DONE. A stray tick never advances the index.
- `i_cmd_valid` is ignored while not in IDLE. The command is not queued; the source must hold it until ready.
- Reset mid-packet: FSM returns to IDLE, index clears, the packet is abandoned, and no `o_pkt_done_tick` is issued. Any in-flight UART byte completes externally and its done tick is ignored.

## Timing
- Reset values: `o_cmd_ready=0` while `rst`=1, then 1 from the first cycle after reset release. `o_tx_start=0`, `o_tx_data=8'h00`, `o_busy=0`, `o_pkt_done_tick=0`.
- Accept at cycle T → `o_tx_start` for byte 0 at T+1. `o_cmd_ready` drops at T+1.
- `i_tx_done_tick` at cycle D, for a non-final byte:
  - `GAP_CLK`=0: next `o_tx_start` at D+1.
  - Otherwise: next `o_tx_start` at D+1+GAP_CLK.
- Final byte's done tick at D → `o_pkt_done_tick` at D+1. IDLE and `o_cmd_ready=1` at D+2. The earliest next accept is D+2.
- No gap is inserted after the last byte.
- All outputs are registered. There is no combinational path from any input to any output.

## Test plan
- Channel 0, one-shot, out=32'h0055_0055, freq=0, through `UART` loopback into `diff_freq_serial_out` → bytes 55 00 55 00 00 00 00 00 01 in order; exactly 9 `o_tx_start` pulses; one `o_pkt_done_tick`; channel 0 output toggles per pattern.
- Channel 13, repeat, out=32'hDEAD_BEEF, freq=32'h0000_FFFF → bytes EF BE AD DE FF FF 00 00 D5; `o_tx_data` stable from each start to its done tick.
- `GAP_CLK`=3 with a model TX whose done arrives 10 cycles after start → each start occurs exactly 4 cycles after the prior done; done→`o_pkt_done_tick` latency is 1 cycle.
- Second command with `i_cmd_valid` held high during a packet → not accepted until D+2 after the final done tick. Back-to-back channel 14 and 15 one-shot packets produce control bytes E1 then F1.
- `rst` pulsed after byte 3's done tick → outputs return to reset values next cycle, no `o_pkt_done_tick`. A following command restarts at byte 0.
- `i_tx_done_tick` injected in IDLE and in the START cycle → index unchanged; the packet still emits all 9 bytes correctly.
